// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t    : one fetch queue slot {pc, instr, filled}
//   NOP_INSTR        : instruction presented to decode when nothing is valid
//   DEFAULT_RESET_PC : default first fetch address after reset
// -----------------------------------------------------------------------------
package core;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular buffer of fetch entries with independent alloc (tail), fill
// (oldest unfilled) and pop (head) pointers.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   flush                : drop every entry (redirect)
//   alloc, alloc_pc      : reserve the tail slot for a newly issued request
//   fill, fill_data      : write a response into the oldest unfilled slot
//   pop                  : retire the head slot
//   head                 : head slot contents
//   count                : occupied slots (allocated, not yet popped)
//   pending              : allocated slots still waiting for their response
// -----------------------------------------------------------------------------
module fetch_queue
   import core::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc,
   input  logic [31:0]   alloc_pc,
   input  logic          fill,
   input  logic [31:0]   fill_data,
   input  logic          pop,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic [CW-1:0] pending
);

   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [PW-1:0]    alloc_ptr;
   logic [PW-1:0]    fill_ptr;
   logic [PW-1:0]    pop_ptr;

   // Control state: pointers, occupancy and filled flags.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         pop_ptr   <= '0;
         count     <= '0;
         pending   <= '0;
         filled_q  <= '0;
      end else begin
         if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
         // fill targets an unfilled slot, pop a filled one: never the same bit
         if (fill) begin
            filled_q[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + 1'b1;
         end
         if (pop) begin
            filled_q[pop_ptr] <= 1'b0;
            pop_ptr           <= pop_ptr + 1'b1;
         end
         count   <= count   + CW'(alloc) - CW'(pop);
         pending <= pending + CW'(alloc) - CW'(fill);
      end
   end

   // Payload storage carries no reset; filled_q qualifies it.
   always_ff @(posedge clk) begin
      if (alloc) pc_q[alloc_ptr]   <= alloc_pc;
      if (fill)  instr_q[fill_ptr] <= fill_data;
   end

   assign head = '{pc: pc_q[pop_ptr], instr: instr_q[pop_ptr], filled: filled_q[pop_ptr]};

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues word fetches, tracks credit
// and the number of wrong-path responses still to be discarded after a
// redirect, and presents {instruction, pc} to decode via valid/ready.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   imem_req_valid_o/ready_i/addr_o : fetch request channel
//   imem_rsp_valid_i/data_i         : in-order response channel (no backpressure)
//   redirect_i, redirect_pc_i       : flush and restart at the new PC
//   id_valid_o/ready_i              : decode handshake
//   instruction_o, pc_o             : head instruction and its PC (NOP/0 when idle)
// -----------------------------------------------------------------------------
module fetch_unit
   import core::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   // Headroom so back-to-back redirects can keep accumulating.
   localparam int DW = $clog2(DEPTH) + 3;

   logic [31:0]   fetch_pc;
   logic [DW-1:0] discard;
   fetch_entry_t  head;
   logic [CW-1:0] count;
   logic [CW-1:0] pending;
   logic          accept;
   logic          rsp_drop;
   logic          fill;
   logic          pop;
   logic [DW:0]   flush_outstanding;
   logic          unused_pc_bits;

   function automatic logic [DW-1:0] sat_discard(input logic [DW:0] v);
      if (v[DW]) return {DW{1'b1}};
      return v[DW-1:0];
   endfunction

   assign unused_pc_bits = &{1'b0, redirect_pc_i[1:0]};

   assign imem_req_valid_o = !rst && !redirect_i && (count < CW'(DEPTH));
   assign imem_addr_o      = fetch_pc;
   assign accept           = imem_req_valid_o && imem_req_ready_i;

   // Responses first pay off the discard debt; redirect beats fill.
   assign rsp_drop = imem_rsp_valid_i && (discard != '0);
   assign fill     = imem_rsp_valid_i && (discard == '0) && (pending != '0) && !redirect_i;
   assign pop      = id_valid_o && id_ready_i;

   // Everything still owed by memory at a redirect becomes discard debt,
   // less the response (if any) that arrives in the redirect cycle itself.
   always_comb begin
      flush_outstanding = {1'b0, discard} + (DW+1)'(pending);
      if (imem_rsp_valid_i && (flush_outstanding != '0))
         flush_outstanding = flush_outstanding - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else if (redirect_i) begin
         fetch_pc <= {redirect_pc_i[31:2], 2'b00};
         discard  <= sat_discard(flush_outstanding);
      end else begin
         if (accept)   fetch_pc <= fetch_pc + 32'd4;
         if (rsp_drop) discard  <= discard - 1'b1;
      end
   end

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_i),
      .alloc     (accept),
      .alloc_pc  (fetch_pc),
      .fill      (fill),
      .fill_data (imem_rsp_data_i),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .pending   (pending)
   );

   assign id_valid_o    = head.filled;
   assign instruction_o = head.filled ? head.instr : NOP_INSTR;
   assign pc_o          = head.filled ? head.pc    : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] W_PC   = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        req_valid, req_ready, rsp_valid, redirect, id_valid, id_ready;
   logic [31:0] addr, rsp_data, redirect_pc, instr, pc;

   logic        w_req_valid, w_req_ready, w_rsp_valid, w_redirect, w_id_valid, w_id_ready;
   logic [31:0] w_addr, w_rsp_data, w_redirect_pc, w_instr, w_pc;

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_addr_o(addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .id_valid_o(id_valid), .id_ready_i(id_ready),
      .instruction_o(instr), .pc_o(pc)
   );

   fetch_unit #(.RESET_PC(W_PC), .DEPTH(2)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready), .imem_addr_o(w_addr),
      .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
      .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
      .id_valid_o(w_id_valid), .id_ready_i(w_id_ready),
      .instruction_o(w_instr), .pc_o(w_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] data; } rsp_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // memory model: in-order responses, per-request latency, at most one per cycle
   rsp_t mq[$];
   int   last_due;
   int   lat_lo = 1, lat_hi = 1, mrdy_pct = 100, rdy_pct = 100, redir_pct = 0;

   // reference model of the decode-visible behaviour
   logic [31:0] exp_req_pc, exp_dec_pc;
   int          entries_m;
   bit          redir_prev, stall_prev;
   logic [31:0] stall_instr, stall_pc;
   int          acc_cnt, delivered, first_acc, first_val;

   // last-cycle observations for directed tests
   bit          last_valid, last_rsp, last_acc;
   logic [31:0] last_pc, last_addr;

   // wrap instance observations
   bit          w_acc_prev;
   logic [31:0] w_prev_addr;
   logic [31:0] w_addrs[$];
   logic [31:0] w_pcs[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69 ^ (a << 7);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic drive_w();
      w_req_ready   = 1'b1;
      w_id_ready    = 1'b1;
      w_redirect    = 1'b0;
      w_redirect_pc = 32'h0;
      w_rsp_valid   = w_acc_prev;
      w_rsp_data    = mem_word(w_prev_addr);
   endtask

   task automatic sample_w();
      bit acc;
      acc = w_req_valid && w_req_ready;
      if (acc && w_addrs.size() < 4) w_addrs.push_back(w_addr);
      if (w_id_valid) begin
         if (w_pcs.size() < 4) w_pcs.push_back(w_pc);
         check("wrap_instr", w_instr, mem_word(w_pc));
      end
      w_acc_prev  = acc;
      w_prev_addr = w_addr;
   endtask

   // Entered and left at posedge+1.
   task automatic do_reset(input int n);
      rst = 1'b1;
      rsp_valid = 1'b0; rsp_data = 32'h0; req_ready = 1'b1; id_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0;
      mq.delete();
      w_acc_prev = 1'b0; w_prev_addr = 32'h0;
      drive_w();
      #1;
      check("rst_req_valid_now", 32'(req_valid), 0);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1; cyc++;
         check("rst_req_valid", 32'(req_valid), 0);
         check("rst_addr",      addr,  RST_PC);
         check("rst_id_valid",  32'(id_valid), 0);
         check("rst_instr",     instr, NOP);
         check("rst_pc",        pc,    32'h0);
         check("rst_wrap_addr", w_addr, W_PC);
      end
      rst = 1'b0;
      last_due = -1; exp_req_pc = RST_PC; exp_dec_pc = RST_PC; entries_m = 0;
      redir_prev = 0; stall_prev = 0; acc_cnt = 0; first_acc = -1; first_val = -1;
      w_addrs.delete(); w_pcs.delete();
   endtask

   task automatic run_cycle(input bit force_redir, input logic [31:0] force_pc);
      bit acc, hs;
      int due;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         rsp_valid = 1'b1; rsp_data = mq[0].data;
      end else begin
         rsp_valid = 1'b0; rsp_data = $urandom;
      end
      req_ready   = ($urandom_range(99) < mrdy_pct);
      id_ready    = ($urandom_range(99) < rdy_pct);
      redirect    = force_redir || ($urandom_range(99) < redir_pct);
      redirect_pc = force_redir ? force_pc : ($urandom & 32'h0000_FFFF);
      drive_w();
      #1;
      if (redir_prev) check("post_redir_valid", 32'(id_valid), 0);
      check("req_valid", 32'(req_valid), 32'(!redirect && entries_m < DEPTH));
      if (req_valid) check("req_addr", addr, exp_req_pc);
      if (!id_valid) begin
         check("idle_instr", instr, NOP);
         check("idle_pc",    pc,    32'h0);
      end
      if (stall_prev) begin
         check("stall_valid", 32'(id_valid), 1);
         check("stall_instr", instr, stall_instr);
         check("stall_pc",    pc,    stall_pc);
      end
      hs  = id_valid && id_ready;
      acc = req_valid && req_ready;
      if (id_valid && first_val < 0) first_val = cyc;
      if (hs) begin
         check("dec_pc",    pc,    exp_dec_pc);
         check("dec_instr", instr, mem_word(exp_dec_pc));
         exp_dec_pc += 32'd4;
         delivered++;
      end
      if (acc) begin
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{due: due, data: mem_word(addr)});
         exp_req_pc += 32'd4;
         acc_cnt++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (rsp_valid) void'(mq.pop_front());
      last_valid = id_valid; last_rsp = rsp_valid; last_pc = pc;
      last_acc = acc; last_addr = addr;
      stall_prev  = id_valid && !id_ready;
      stall_instr = instr;
      stall_pc    = pc;
      entries_m   = entries_m + int'(acc) - int'(hs);
      redir_prev  = redirect;
      if (redirect) begin
         entries_m  = 0;
         stall_prev = 0;
         exp_req_pc = {redirect_pc[31:2], 2'b00};
         exp_dec_pc = {redirect_pc[31:2], 2'b00};
      end
      sample_w();
      @(posedge clk); #1; cyc++;
   endtask

   initial begin
      int cnt;
      bit found;
      delivered = 0;

      // 1: reset, 1-cycle memory, decode always ready
      do_reset(3);
      lat_lo = 1; lat_hi = 1; mrdy_pct = 100; rdy_pct = 100; redir_pct = 0;
      for (int i = 0; i < 10; i++) run_cycle(0, 32'h0);
      check("first_valid_lat", 32'(first_val - first_acc), 2);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle(0, 32'h0);
         cnt += int'(last_valid);
      end
      check("throughput", 32'(cnt), 20);
      if (w_addrs.size() >= 3 && w_pcs.size() >= 3) begin
         check("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
         check("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
         check("wrap_addr2", w_addrs[2], 32'h0000_0000);
         check("wrap_pc2",   w_pcs[2],   32'h0000_0000);
      end else begin
         check("wrap_count", 32'(w_addrs.size()), 3);
      end

      // 2: decode stalls, queue fills to DEPTH then resumes
      do_reset(1);
      rdy_pct = 0;
      for (int i = 0; i < 8; i++) run_cycle(0, 32'h0);
      check("stall_accepts", 32'(acc_cnt), DEPTH);
      check("stall_req_low", 32'(req_valid), 0);
      rdy_pct = 100;
      for (int i = 0; i < 20; i++) run_cycle(0, 32'h0);

      // 6: reset with a full queue, fetch resumes from RESET_PC
      rdy_pct = 0;
      for (int i = 0; i < 8; i++) run_cycle(0, 32'h0);
      check("full_before_rst", 32'(id_valid), 1);
      do_reset(1);
      rdy_pct = 100;
      for (int i = 0; i < 10; i++) run_cycle(0, 32'h0);

      // 3: 3-cycle memory, two outstanding, redirect to a misaligned target
      do_reset(1);
      lat_lo = 3; lat_hi = 3;
      run_cycle(0, 32'h0);
      run_cycle(0, 32'h0);
      run_cycle(1, 32'h0000_0102);
      run_cycle(0, 32'h0);
      check("redir_acc",  32'(last_acc), 1);
      check("redir_addr", last_addr, 32'h0000_0100);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(0, 32'h0);
         found = last_valid;
      end
      check("redir_found",    32'(found), 1);
      check("redir_first_pc", last_pc, 32'h0000_0100);
      for (int i = 0; i < 10; i++) run_cycle(0, 32'h0);

      // 4: redirect together with a response and a decode handshake
      do_reset(1);
      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 10; i++) run_cycle(0, 32'h0);
      run_cycle(1, 32'h0000_0200);
      check("r4_cond", {30'h0, last_valid, last_rsp}, 32'h3);
      run_cycle(0, 32'h0);
      check("r4_v1", 32'(last_valid), 0);
      run_cycle(0, 32'h0);
      check("r4_v2", 32'(last_valid), 0);
      run_cycle(0, 32'h0);
      check("r4_v3",  32'(last_valid), 1);
      check("r4_pc3", last_pc, 32'h0000_0200);

      // randomized traffic against the reference model
      do_reset(1);
      lat_lo = 1; lat_hi = 4; mrdy_pct = 75; rdy_pct = 70; redir_pct = 3;
      delivered = 0;
      for (int i = 0; i < 3000; i++) run_cycle(0, 32'h0);
      check("progress", 32'(delivered > 300), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
